// File: rtl/math_seq_pkg.sv
// Shared definitions for the math pipelined sequencer slice.
//   state_t   : sequencer FSM states (IDLE/SETTLE/DONE)
//   FLAG_*    : bit positions inside the ALU flag vector {neq,eq,xor,or,and}
//   clog2     : counter width helper (never returns less than 1)
package math_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned FLAG_AND = 0;
  localparam int unsigned FLAG_OR  = 1;
  localparam int unsigned FLAG_XOR = 2;
  localparam int unsigned FLAG_EQ  = 3;
  localparam int unsigned FLAG_NEQ = 4;
  localparam int unsigned FLAG_W   = 5;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/math_settle_timer.sv
// Loadable down-counter that measures the operand settle window.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the counter with SETTLE_CYCLES-1
//   dec_en   : count down by one (saturates at zero)
//   zero     : counter currently at zero
module math_settle_timer
  import math_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec_en,
  output logic zero
);

  localparam int unsigned CNT_W = clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec_en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/math_pipelined_sequencer.sv
// Issue/retire stage around the pipelined ALU. Accepts an operand triple,
// holds it on alu_i1..3 for SETTLE_CYCLES edges, then captures the ALU
// results into an output register with its own valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake, in_a/in_b/in_c operands
//   alu_i1/alu_i2/alu_i3 : registered operands driven to the ALU
//   alu_sum/sub/flags    : ALU results, flags = {neq,eq,xor,or,and}
//   out_valid/out_ready  : result handshake, out_sum/out_sub/out_flags
//   busy                 : FSM not idle
// Optional build macro MATH_SEQ_SETTLE_CHECK_EN adds a sticky err output and
// one extra settle cycle that re-samples the results to detect instability.
module math_pipelined_sequencer
  import math_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned SETTLE_CYCLES = LATENCY + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_c,
  output logic [WIDTH-1:0]  alu_i1,
  output logic [WIDTH-1:0]  alu_i2,
  output logic [WIDTH-1:0]  alu_i3,
  input  logic [WIDTH-1:0]  alu_sum,
  input  logic [WIDTH-1:0]  alu_sub,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [WIDTH-1:0]  out_sub,
  output logic [FLAG_W-1:0] out_flags,
  output logic              busy
`ifdef MATH_SEQ_SETTLE_CHECK_EN
  ,
  output logic              err
`endif
);

  if (SETTLE_CYCLES == 0) begin : g_bad_settle
    $error("math_pipelined_sequencer: SETTLE_CYCLES must be at least 1");
  end

  state_t state, state_next;
  logic   accept, capture, out_fire, timer_zero, settle_done;

  math_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .dec_en (state == SETTLE),
    .zero   (timer_zero)
  );

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign capture  = (state == SETTLE) & settle_done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SETTLE;
      end
      SETTLE: begin
        if (capture) state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? SETTLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accept from DONE coincides with out_fire, so out_valid drops on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_i1    <= '0;
      alu_i2    <= '0;
      alu_i3    <= '0;
      out_sum   <= '0;
      out_sub   <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        alu_i1 <= in_a;
        alu_i2 <= in_b;
        alu_i3 <= in_c;
      end
      if (capture) begin
        out_sum   <= alu_sum;
        out_sub   <= alu_sub;
        out_flags <= alu_flags;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MATH_SEQ_SETTLE_CHECK_EN
  // First time the timer reaches zero the results are snapshotted and the FSM
  // stays in SETTLE one more edge; the second sample is captured and compared.
  logic              sampled;
  logic [WIDTH-1:0]  snap_sum, snap_sub;
  logic [FLAG_W-1:0] snap_flags;

  assign settle_done = timer_zero & sampled;

  always_ff @(posedge clk) begin
    if (rst) begin
      sampled    <= 1'b0;
      snap_sum   <= '0;
      snap_sub   <= '0;
      snap_flags <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        sampled <= 1'b0;
      end else if ((state == SETTLE) && timer_zero && !sampled) begin
        sampled    <= 1'b1;
        snap_sum   <= alu_sum;
        snap_sub   <= alu_sub;
        snap_flags <= alu_flags;
      end
      if (capture && ({snap_sum, snap_sub, snap_flags} != {alu_sum, alu_sub, alu_flags}))
        err <= 1'b1;
    end
  end
`else
  assign settle_done = timer_zero;
`endif

endmodule
